jtag_master: RTL and testbench

//  Synthesisable JTAG initiator that drives TCK/TMS/TDI into the design's TAP
//  (jtag_tap / jtag_dr) and captures TDO; the host side of the JTAG link.
//  It replaces hand-written TAP stimulus: a bench or on-chip sequencer issues
//  "shift IR" / "shift DR" commands and gets back the captured TDO word.
//  All TAP walks start and end in Run-Test/Idle.

---
 rtl/jtag_master_if.sv | 18 +
 rtl/jtag_master.sv | 186 ++++++++++++++++++
 tb/tb_jtag_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_master_if.sv
`timescale 1ns/1ps
// Command/response bus between a JTAG host sequencer and jtag_master.
// master = the sequencer issuing commands, slave = jtag_master.
interface jtag_master_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
);
  logic               start;
  logic               is_ir;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] data_in;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] data_out;

  modport master (output start, is_ir, len, data_in, input busy, done, data_out);
  modport slave  (input start, is_ir, len, data_in, output busy, done, data_out);
endinterface

// File: rtl/jtag_master.sv
`timescale 1ns/1ps
// JTAG initiator: walks the TAP from Run-Test/Idle through Shift-IR/DR and back,
// shifting data_in out on TDI and capturing TDO into data_out.
//
// state      | meaning
// RESET_WALK | 5x TMS=1 then TMS=0: Test-Logic-Reset -> Run-Test/Idle
// IDLE       | TAP parked in Run-Test/Idle, waiting for start
// PRE        | Select-DR [, Select-IR], Capture, into Shift
// SHIFT      | len bits on TDI/TDO, TMS=1 on the last bit (-> Exit1)
// POST       | Update, back to Run-Test/Idle
module jtag_master #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6,
  parameter int TCK_DIV = 2
) (
  input  logic         clk_50_,
  input  logic         reset_,
  jtag_master_if.slave cmd,
  input  logic         tdo,
  output logic         tck,
  output logic         tms,
  output logic         tdi
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  typedef enum logic [2:0] {RESET_WALK, IDLE, PRE, SHIFT, POST} state_e;

  state_e             state, state_nx;
  logic [DIV_W-1:0]   div_cnt, div_nx;
  logic [LEN_W-1:0]   seq_cnt, seq_nx;
  logic [LEN_W-1:0]   len_q, len_nx;
  logic               ir_q, ir_nx;
  logic [MAX_LEN-1:0] sh_q, sh_nx;
  logic [MAX_LEN-1:0] dout_q, dout_nx;
  logic               busy_q, busy_nx;
  logic               done_q, done_nx;
  logic               tck_nx, tms_nx, tdi_nx;

  logic               half_end, rise, fall, len_ok;
  logic [LEN_W-1:0]   seq_inc, last_pre, last_bit;

  assign half_end = (div_cnt == DIV_W'(TCK_DIV - 1));
  assign rise     = half_end & ~tck;
  assign fall     = half_end & tck;
  assign seq_inc  = (seq_cnt == '1) ? seq_cnt : seq_cnt + LEN_W'(1);
  assign last_pre = ir_q ? LEN_W'(3) : LEN_W'(2);
  assign last_bit = len_q - LEN_W'(1);
  assign len_ok   = (cmd.len != '0) && (cmd.len <= LEN_W'(MAX_LEN));

  always_ff @(posedge clk_50_ or posedge reset_) begin
    if (reset_) begin
      state   <= RESET_WALK;
      div_cnt <= '0;
      seq_cnt <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      sh_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      tck     <= 1'b0;
      tms     <= 1'b1;
      tdi     <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      seq_cnt <= seq_nx;
      len_q   <= len_nx;
      ir_q    <= ir_nx;
      sh_q    <= sh_nx;
      dout_q  <= dout_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      tck     <= tck_nx;
      tms     <= tms_nx;
      tdi     <= tdi_nx;
    end
  end

  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    seq_nx   = seq_cnt;
    len_nx   = len_q;
    ir_nx    = ir_q;
    sh_nx    = sh_q;
    dout_nx  = dout_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    tck_nx   = tck;
    tms_nx   = tms;
    tdi_nx   = tdi;

    // TCK runs whenever a walk is in progress; IDLE parks it low.
    if (state != IDLE) begin
      div_nx = half_end ? '0 : div_cnt + DIV_W'(1);
      if (rise) tck_nx = 1'b1;
      if (fall) tck_nx = 1'b0;
    end

    case (state)
      RESET_WALK: begin
        if (fall) begin
          if (seq_cnt == LEN_W'(5)) begin
            state_nx = IDLE;
            seq_nx   = '0;
            busy_nx  = 1'b0;
            tms_nx   = 1'b0;
          end else begin
            seq_nx = seq_inc;
            tms_nx = (seq_inc != LEN_W'(5));
          end
        end
      end
      IDLE: begin
        if (cmd.start && len_ok) begin
          state_nx = PRE;
          busy_nx  = 1'b1;
          len_nx   = cmd.len;
          ir_nx    = cmd.is_ir;
          sh_nx    = cmd.data_in;
          dout_nx  = '0;
          seq_nx   = '0;
          div_nx   = '0;
          tms_nx   = 1'b1;
          tdi_nx   = 1'b0;
        end
      end
      PRE: begin
        if (fall) begin
          if (seq_cnt == last_pre) begin
            state_nx = SHIFT;
            seq_nx   = '0;
            tms_nx   = (len_q == LEN_W'(1));
            tdi_nx   = sh_q[0];
          end else begin
            seq_nx = seq_inc;
            tms_nx = ir_q && (seq_inc == LEN_W'(1));
            tdi_nx = 1'b0;
          end
        end
      end
      SHIFT: begin
        if (rise) begin
          for (int i = 0; i < MAX_LEN; i++)
            if (seq_cnt == LEN_W'(i)) dout_nx[i] = tdo;
        end
        if (fall) begin
          if (seq_cnt == last_bit) begin
            state_nx = POST;
            seq_nx   = '0;
            tms_nx   = 1'b1;
            tdi_nx   = 1'b0;
          end else begin
            seq_nx = seq_inc;
            sh_nx  = sh_q >> 1;
            tdi_nx = sh_q[1];
            tms_nx = (seq_inc == last_bit);
          end
        end
      end
      POST: begin
        if (fall) begin
          if (seq_cnt == LEN_W'(1)) begin
            state_nx = IDLE;
            seq_nx   = '0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            tms_nx   = 1'b0;
            tdi_nx   = 1'b0;
          end else begin
            seq_nx = seq_inc;
            tms_nx = 1'b0;
          end
        end
      end
      default: state_nx = RESET_WALK;
    endcase
  end

  assign cmd.busy     = busy_q;
  assign cmd.done     = done_q;
  assign cmd.data_out = dout_q;

endmodule

// File: tb/tb_jtag_master.sv
`timescale 1ns/1ps
// Bench for jtag_master: two DUTs (TCK_DIV=2 and 1) share one IEEE 1149.1 TAP
// model through a select mux; completions are scored against a queue.
module tb_jtag_master;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam logic [9:0] IR_CAP = 10'h151;
  localparam logic [9:0] IR_RST = 10'h001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic tdo = 1'b0;
  logic tck_a, tms_a, tdi_a, tck_b, tms_b, tdi_b;

  always #5 clk = ~clk;

  jtag_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) ifa ();
  jtag_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) ifb ();

  jtag_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TCK_DIV(2)) dut_a (
    .clk_50_(clk), .reset_(rst), .cmd(ifa), .tdo(tdo),
    .tck(tck_a), .tms(tms_a), .tdi(tdi_a));

  jtag_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TCK_DIV(1)) dut_b (
    .clk_50_(clk), .reset_(rst), .cmd(ifb), .tdo(tdo),
    .tck(tck_b), .tms(tms_b), .tdi(tdi_b));

  wire tck_m = sel ? tck_b : tck_a;
  wire tms_m = sel ? tms_b : tms_a;
  wire tdi_m = sel ? tdi_b : tdi_a;

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
                            UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR,
                            UPD_IR} tap_e;
  tap_e        st = TLR;
  logic [31:0] dr_sr = '0, dr_cap = '0, dr_upd = '0;
  int          dr_len = 8;
  logic [9:0]  ir_sr = '0, ir_upd = IR_RST;
  bit          tms_q[$];
  bit          tdi_q[$];

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PAU_DR;
      PAU_DR: return m ? EX2_DR : PAU_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PAU_IR;
      PAU_IR: return m ? EX2_IR : PAU_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck_m) begin
    tms_q.push_back(tms_m);
    case (st)
      CAP_DR: dr_sr <= dr_cap;
      SH_DR: begin
        dr_sr <= (dr_sr >> 1) | (32'(tdi_m) << (dr_len - 1));
        tdi_q.push_back(tdi_m);
      end
      CAP_IR: ir_sr <= IR_CAP;
      SH_IR: begin
        ir_sr <= {tdi_m, ir_sr[9:1]};
        tdi_q.push_back(tdi_m);
      end
      default: ;
    endcase
    st <= tap_next(st, tms_m);
  end

  always @(negedge tck_m) begin
    tdo <= (st == SH_DR) ? dr_sr[0] : (st == SH_IR) ? ir_sr[0] : 1'b0;
    if (st == UPD_DR) dr_upd <= dr_sr;
    if (st == UPD_IR) ir_upd <= ir_sr;
    if (st == TLR)    ir_upd <= IR_RST;
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [MAX_LEN-1:0] exp_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (ifa.done || ifb.done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("sb_empty_at_done", 64'(exp_q.size()), 64'd1);
      else chk("data_out", sel ? ifb.data_out : ifa.data_out, exp_q.pop_front());
    end
  end

  function automatic logic [63:0] tms_bits(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < 64; i++)
      if (base + i < tms_q.size()) v[i] = tms_q[base + i];
    return v;
  endfunction

  function automatic logic [63:0] tdi_bits(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < 64; i++)
      if (base + i < tdi_q.size()) v[i] = tdi_q[base + i];
    return v;
  endfunction

  function automatic logic cur_busy();
    return sel ? ifb.busy : ifa.busy;
  endfunction

  task automatic drive(input logic ir, input logic [LEN_W-1:0] l, input logic [31:0] d,
                       input logic s);
    ifa.is_ir = ir; ifa.len = l; ifa.data_in = d; ifa.start = s & ~sel;
    ifb.is_ir = ir; ifb.len = l; ifb.data_in = d; ifb.start = s & sel;
  endtask

  // Issue one command, score its result, check timing and the TMS/TDI streams.
  // poke > 0 re-strobes start (with different fields) that many clk into the run.
  task automatic run_cmd(input string nm, input logic ir, input int ln, input logic [31:0] din,
                         input logic [31:0] exp, input int exp_tck, input logic [63:0] exp_tms,
                         input int div, input int poke);
    int t0, s0, d0, n;
    t0 = tms_q.size();
    s0 = tdi_q.size();
    d0 = done_cnt;
    @(negedge clk);
    drive(ir, LEN_W'(ln), din, 1'b1);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    chk({nm, "_busy_rise"}, 64'(cur_busy()), 64'd1);
    drive(ir, LEN_W'(ln), din, 1'b0);
    n = 0;
    while (cur_busy() && n < 5000) begin
      if (poke > 0 && n == poke)     drive(~ir, LEN_W'(4), 32'h0, 1'b1);
      if (poke > 0 && n == poke + 1) drive(~ir, LEN_W'(4), 32'h0, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    drive(1'b0, '0, '0, 1'b0);
    chk({nm, "_busy_clks"}, 64'(n), 64'(exp_tck * 2 * div));
    repeat (2) @(negedge clk);
    chk({nm, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_tck_cnt"}, 64'(tms_q.size() - t0), 64'(exp_tck));
    chk({nm, "_tms_seq"}, tms_bits(t0, exp_tck), exp_tms);
    chk({nm, "_tdi_bits"}, tdi_bits(s0, ln), 64'(din) & ((64'h1 << ln) - 64'h1));
    chk({nm, "_tap_rti"}, 64'(st), 64'(RTI));
  endtask

  task automatic walk_check(input string nm);
    int t0, n;
    t0 = tms_q.size();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (ifa.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_clks"}, 64'(n), 64'd24);
    repeat (2) @(negedge clk);
    chk({nm, "_tck_cnt"}, 64'(tms_q.size() - t0), 64'd6);
    chk({nm, "_tms_seq"}, tms_bits(t0, 6), 64'h1F);
    chk({nm, "_tap_rti"}, 64'(st), 64'(RTI));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0, n, busy_seen;
    logic [LEN_W-1:0] bad_len[2];
    drive(1'b0, '0, '0, 1'b0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_tck", 64'(tck_a), 64'd0);
    chk("rst_tms", 64'(tms_a), 64'd1);
    chk("rst_tdi", 64'(tdi_a), 64'd0);
    chk("rst_busy", 64'(ifa.busy), 64'd1);
    chk("rst_done", 64'(ifa.done), 64'd0);
    chk("rst_data_out", 64'(ifa.data_out), 64'd0);

    // post-reset TLR walk
    walk_check("walk");
    chk("walk_no_done", 64'(done_cnt), 64'd0);

    // DR len 8
    dr_len = 8; dr_cap = 32'h3C;
    run_cmd("dr8", 1'b0, 8, 32'hA5, 32'h3C, 13, 64'hC01, 2, 0);
    chk("dr8_update", 64'(dr_upd), 64'hA5);

    // IR len 10
    run_cmd("ir10", 1'b1, 10, 32'h3FE, 32'(IR_CAP), 16, 64'h6003, 2, 0);
    chk("ir10_update", 64'(ir_upd), 64'h3FE);

    // start while busy is ignored
    dr_cap = 32'h96;
    run_cmd("busy_poke", 1'b0, 8, 32'h0F, 32'h96, 13, 64'hC01, 2, 5);
    chk("busy_poke_update", 64'(dr_upd), 64'h0F);

    // out-of-range len is ignored
    bad_len[0] = LEN_W'(0);
    bad_len[1] = LEN_W'(33);
    for (int k = 0; k < 2; k++) begin
      t0 = tms_q.size();
      d0 = done_cnt;
      busy_seen = 0;
      @(negedge clk);
      drive(1'b0, bad_len[k], 32'hFFFF_FFFF, 1'b1);
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0);
      for (int c = 0; c < 20; c++) begin
        if (ifa.busy) busy_seen = 1;
        @(negedge clk);
      end
      chk($sformatf("badlen%0d_busy", k), 64'(busy_seen), 64'd0);
      chk($sformatf("badlen%0d_tck", k), 64'(tms_q.size() - t0), 64'd0);
      chk($sformatf("badlen%0d_done", k), 64'(done_cnt - d0), 64'd0);
      chk($sformatf("badlen%0d_data_out", k), 64'(ifa.data_out), 64'h96);
    end

    // reset during SHIFT bit 3
    dr_cap = 32'h3C;
    t0 = tms_q.size();
    @(negedge clk);
    drive(1'b0, LEN_W'(8), 32'hA5, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    n = 0;
    while (!((tms_q.size() - t0) == 6 && !tck_a) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_bit3", 64'(n < 500), 64'd1);
    chk("midrst_partial", 64'(ifa.data_out), 64'h4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tck", 64'(tck_a), 64'd0);
    chk("midrst_tms", 64'(tms_a), 64'd1);
    chk("midrst_busy", 64'(ifa.busy), 64'd1);
    chk("midrst_done", 64'(ifa.done), 64'd0);
    chk("midrst_data_out", 64'(ifa.data_out), 64'd0);
    repeat (2) @(negedge clk);
    walk_check("rewalk");
    dr_cap = 32'hC3;
    run_cmd("after_rst", 1'b0, 8, 32'h5A, 32'hC3, 13, 64'hC01, 2, 0);
    chk("after_rst_update", 64'(dr_upd), 64'h5A);

    // TCK_DIV=1, full-width DR
    @(negedge clk);
    sel = 1'b1;
    dr_len = 32; dr_cap = 32'h1234_5678;
    run_cmd("div1_dr32", 1'b0, 32, 32'hFFFF_FFFF, 32'h1234_5678, 37,
            64'h1 | (64'h3 << 34), 1, 0);
    chk("div1_dr32_update", 64'(dr_upd), 64'hFFFF_FFFF);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
